// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared sequencer state and trap cause encodings
package core_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    INCR_PC = 3'd5,
    TRAP    = 3'd6
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_ILLEGAL  = 3'd1,
    CAUSE_FETCH_TO = 3'd2,
    CAUSE_MEM_TO   = 3'd3,
    CAUSE_MISALIGN = 3'd4
  } trap_cause_t;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_timeout.sv
// rtl/req_timeout.sv - request-without-ack watchdog shared by fetch and data access
module req_timeout
  import core_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the number of earlier unacknowledged request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || ack) begin
      r_cnt <= '0;
    end else if (req && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (LIMIT != 0) && req && !ack && (r_cnt == LAST);

endmodule

// File: rtl/ctrl_seq_fsm.sv
// rtl/ctrl_seq_fsm.sv - fetch/decode/execute/memory/writeback sequencer for the serial-ALU core
module ctrl_seq_fsm
  import core_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned MEM_TIMEOUT = 16,
  localparam int unsigned NDIG       = XLEN / DIGIT_W,
  localparam int unsigned DW         = cnt_width(NDIG)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_q,
  input  logic            dec_illegal,
  input  logic            dec_need_alu,
  input  logic            dec_need_mem,
  input  logic            dec_mem_we,
  input  logic            dec_need_wb,
  output logic            alu_en,
  output logic [DW-1:0]   alu_digit,
  output logic            alu_first,
  output logic            alu_last,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc,
  output ctrl_state_t     state,
  output logic            trap,
  output trap_cause_t     trap_cause
);

  if (XLEN % DIGIT_W != 0) begin : g_bad_digit_w
    $error("XLEN must be a multiple of DIGIT_W");
  end
  if (PC_STEP == 0 || (PC_STEP & (PC_STEP - 1)) != 0) begin : g_bad_pc_step
    $error("PC_STEP must be a power of two");
  end

  localparam logic [DW-1:0]   LAST_DIG = DW'(NDIG - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_M  = XLEN'(PC_STEP - 1);

  ctrl_state_t     r_state;
  ctrl_state_t     w_next;
  trap_cause_t     r_cause;
  trap_cause_t     w_cause;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [DW-1:0]   r_digit;
  logic            r_need_mem;
  logic            r_mem_we;
  logic            r_need_wb;
  logic            r_trap;
  logic            w_pc_load;
  logic            w_misaligned;
  logic            w_to_req;
  logic            w_to_ack;
  logic            w_expired;

  // Derived from state alone so the watchdog never sits in a loop with the FSM decode.
  assign w_to_req     = (r_state == FETCH) || (r_state == MEM);
  assign w_to_ack     = (r_state == FETCH) ? imem_ack : dmem_ack;
  assign w_misaligned = (br_target & ALIGN_M) != '0;

  req_timeout #(
    .LIMIT (MEM_TIMEOUT)
  ) u_req_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!w_to_req),
    .req     (w_to_req),
    .ack     (w_to_ack),
    .expired (w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_cause   = CAUSE_NONE;
    w_pc_load = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_en    = 1'b0;
    alu_first = 1'b0;
    alu_last  = 1'b0;
    rf_we     = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_next = DECODE;
        end else if (w_expired) begin
          w_next  = TRAP;
          w_cause = CAUSE_FETCH_TO;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          w_next  = TRAP;
          w_cause = CAUSE_ILLEGAL;
        end else if (dec_need_alu) begin
          w_next = EXEC;
        end else if (dec_need_mem) begin
          w_next = MEM;
        end else if (dec_need_wb) begin
          w_next = WB;
        end else begin
          w_next = INCR_PC;
        end
      end
      EXEC: begin
        alu_en    = 1'b1;
        alu_first = (r_digit == '0);
        alu_last  = (r_digit == LAST_DIG);
        if (alu_last) begin
          w_next = r_need_mem ? MEM : (r_need_wb ? WB : INCR_PC);
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_mem_we;
        if (dmem_ack) begin
          w_next = r_need_wb ? WB : INCR_PC;
        end else if (w_expired) begin
          w_next  = TRAP;
          w_cause = CAUSE_MEM_TO;
        end
      end
      WB: begin
        rf_we  = 1'b1;
        w_next = INCR_PC;
      end
      INCR_PC: begin
        if (br_taken && w_misaligned) begin
          w_next  = TRAP;
          w_cause = CAUSE_MISALIGN;
        end else begin
          w_pc_load = 1'b1;
          w_next    = FETCH;
        end
      end
      TRAP: begin
        w_next = TRAP;
      end
      default: begin
        w_next = TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_trap  <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      if (w_next == TRAP && r_state != TRAP) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_need_mem <= 1'b0;
      r_mem_we   <= 1'b0;
      r_need_wb  <= 1'b0;
    end else begin
      if (r_state == FETCH && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (r_state == DECODE) begin
        r_need_mem <= dec_need_mem;
        r_mem_we   <= dec_mem_we;
        r_need_wb  <= dec_need_wb;
      end
      if (w_pc_load) begin
        r_pc <= br_taken ? br_target : r_pc + STEP;
      end
    end
  end

  // The digit counter only moves inside EXEC, so it reads zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (r_state == EXEC && r_digit != LAST_DIG) begin
      r_digit <= r_digit + DW'(1);
    end else begin
      r_digit <= '0;
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign instr_q    = r_instr;
  assign alu_digit  = r_digit;
  assign state      = r_state;
  assign trap       = r_trap;
  assign trap_cause = r_cause;

endmodule

// File: tb/tb_ctrl_seq_fsm.sv
// tb/tb_ctrl_seq_fsm.sv - trace-model self-checking bench for ctrl_seq_fsm
module tb_ctrl_seq_fsm;
  import core_pkg::*;

  localparam int          NDIG   = 8;
  localparam int          TO     = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_q;
  logic        dec_illegal, dec_need_alu, dec_need_mem, dec_mem_we, dec_need_wb;
  logic        alu_en;
  logic [2:0]  alu_digit;
  logic        alu_first, alu_last;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  ctrl_state_t state;
  logic        trap;
  trap_cause_t trap_cause;

  ctrl_seq_fsm #(
    .XLEN(32), .DIGIT_W(4), .PC_STEP(4), .RESET_PC(RST_PC), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_q(instr_q),
    .dec_illegal(dec_illegal), .dec_need_alu(dec_need_alu), .dec_need_mem(dec_need_mem),
    .dec_mem_we(dec_mem_we), .dec_need_wb(dec_need_wb),
    .alu_en(alu_en), .alu_digit(alu_digit), .alu_first(alu_first), .alu_last(alu_last),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs that cycle must show.
  typedef struct {
    logic        ia;
    logic [31:0] rd;
    logic        ill, alu, mem, we, wb;
    logic        da;
    logic        bt;
    logic [31:0] tgt;
    logic [2:0]  st;
    logic        ireq, dreq, dwe, aen;
    logic [2:0]  dig;
    logic        af, al, rfwe;
    logic [31:0] pc, iq;
    logic        tr;
    logic [2:0]  cause;
  } rec_t;

  rec_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          obs_rf, obs_dreq;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_trap;
  logic [2:0]  m_cause;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic rec_t mk(input ctrl_state_t s);
    rec_t r;
    r.ia  = 1'($urandom); r.rd = $urandom;
    r.ill = 1'($urandom); r.alu = 1'($urandom); r.mem = 1'($urandom);
    r.we  = 1'($urandom); r.wb = 1'($urandom);
    r.da  = 1'($urandom); r.bt = 1'($urandom); r.tgt = $urandom;
    r.st  = 3'(s);
    r.ireq = 1'b0; r.dreq = 1'b0; r.dwe = 1'b0; r.aen = 1'b0;
    r.dig  = 3'd0; r.af = 1'b0; r.al = 1'b0; r.rfwe = 1'b0;
    r.pc   = m_pc; r.iq = m_instr; r.tr = m_trap; r.cause = m_cause;
    return r;
  endfunction

  task automatic add_trap(input logic [2:0] cause);
    m_trap  = 1'b1;
    m_cause = cause;
    for (int k = 0; k < 4; k++) q.push_back(mk(TRAP));
  endtask

  // Expands one instruction into its expected cycle trace.
  task automatic add_instr(input logic [31:0] word, input bit ill, input bit alu, input bit mem,
                           input bit we, input bit wb, input int fw, input int mw,
                           input bit bt, input logic [31:0] tgt);
    rec_t r;
    for (int k = 0; k <= fw; k++) begin
      r = mk(FETCH);
      r.ireq = 1'b1;
      r.ia   = (k == fw);
      r.rd   = r.ia ? word : $urandom;
      q.push_back(r);
      if (k == TO - 1 && k != fw) begin
        add_trap(3'd2);
        return;
      end
    end
    m_instr = word;
    r = mk(DECODE);
    r.ill = ill; r.alu = alu; r.mem = mem; r.we = we; r.wb = wb;
    q.push_back(r);
    if (ill) begin
      add_trap(3'd1);
      return;
    end
    if (alu) begin
      for (int d = 0; d < NDIG; d++) begin
        r = mk(EXEC);
        r.aen = 1'b1; r.dig = 3'(d); r.af = (d == 0); r.al = (d == NDIG - 1);
        q.push_back(r);
      end
    end
    if (mem) begin
      for (int k = 0; k <= mw; k++) begin
        r = mk(MEM);
        r.dreq = 1'b1; r.dwe = we; r.da = (k == mw);
        q.push_back(r);
        if (k == TO - 1 && k != mw) begin
          add_trap(3'd3);
          return;
        end
      end
    end
    if (wb) begin
      r = mk(WB);
      r.rfwe = 1'b1;
      q.push_back(r);
    end
    r = mk(INCR_PC);
    r.bt = bt; r.tgt = tgt;
    q.push_back(r);
    if (bt && (tgt % 4) != 0) add_trap(3'd4);
    else m_pc = bt ? tgt : m_pc + 32'd4;
  endtask

  task automatic cmp(input rec_t r);
    chk("state",      32'(state),      32'(r.st));
    chk("imem_req",   32'(imem_req),   32'(r.ireq));
    chk("imem_addr",  imem_addr,       r.pc);
    chk("pc",         pc,              r.pc);
    chk("instr_q",    instr_q,         r.iq);
    chk("alu_en",     32'(alu_en),     32'(r.aen));
    chk("alu_digit",  32'(alu_digit),  32'(r.dig));
    chk("alu_first",  32'(alu_first),  32'(r.af));
    chk("alu_last",   32'(alu_last),   32'(r.al));
    chk("dmem_req",   32'(dmem_req),   32'(r.dreq));
    chk("dmem_we",    32'(dmem_we),    32'(r.dwe));
    chk("rf_we",      32'(rf_we),      32'(r.rfwe));
    chk("trap",       32'(trap),       32'(r.tr));
    chk("trap_cause", 32'(trap_cause), 32'(r.cause));
  endtask

  // Inputs change and outputs are compared on the falling edge.
  task automatic run_trace(input bit hold);
    obs_rf   = 0;
    obs_dreq = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clk);
      imem_ack = q[i].ia; imem_rdata = q[i].rd;
      dec_illegal = q[i].ill; dec_need_alu = q[i].alu; dec_need_mem = q[i].mem;
      dec_mem_we = q[i].we; dec_need_wb = q[i].wb;
      dmem_ack = q[i].da; br_taken = q[i].bt; br_target = q[i].tgt;
      #1;
      cmp(q[i]);
      obs_rf   += int'(rf_we);
      obs_dreq += int'(dmem_req);
    end
    if (!hold) @(negedge clk);
    q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state",     32'(state),      32'(FETCH));
    chk("rst_pc",        pc,              RST_PC);
    chk("rst_imem_addr", imem_addr,       RST_PC);
    chk("rst_instr_q",   instr_q,         32'd0);
    chk("rst_imem_req",  32'(imem_req),   32'd1);
    chk("rst_alu_en",    32'(alu_en),     32'd0);
    chk("rst_alu_digit", 32'(alu_digit),  32'd0);
    chk("rst_dmem_req",  32'(dmem_req),   32'd0);
    chk("rst_rf_we",     32'(rf_we),      32'd0);
    chk("rst_trap",      32'(trap),       32'd0);
    chk("rst_cause",     32'(trap_cause), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = RST_PC;
    m_instr = 32'd0;
    m_trap  = 1'b0;
    m_cause = 3'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          r_ill, r_alu, r_mem, r_we, r_wb, r_bt;
    logic [31:0] r_tgt;
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; dec_illegal = 1'b0; dec_need_alu = 1'b0;
    dec_need_mem = 1'b0; dec_mem_we = 1'b0; dec_need_wb = 1'b0;
    dmem_ack = 1'b0; br_taken = 1'b0; br_target = '0;
    @(negedge clk);
    do_reset();

    // addi: FETCH, DECODE, 8 x EXEC, WB, INCR_PC
    add_instr(32'h0010_0093, 0, 1, 0, 0, 1, 0, 0, 0, 32'd0);
    chk("addi_cycles", q.size(), 32'd12);
    run_trace(0);
    chk("addi_pc", pc, 32'h104);
    chk("addi_rf_we_pulses", obs_rf, 32'd1);

    // load with ALU address phase and three wait cycles on the data bus
    add_instr(32'h0000_2083, 0, 1, 1, 0, 1, 0, 3, 0, 32'd0);
    run_trace(0);
    chk("load_dmem_req_cycles", obs_dreq, 32'd4);
    chk("load_pc", pc, 32'h108);

    // memory-only store, no writeback
    add_instr(32'h0010_2023, 0, 0, 1, 1, 0, 1, 2, 0, 32'd0);
    run_trace(0);

    add_instr(32'h0000_006F, 0, 0, 0, 0, 1, 0, 0, 1, 32'h200);
    run_trace(0);
    chk("branch_pc", pc, 32'h200);
    add_instr(32'h0000_006F, 0, 0, 0, 0, 1, 0, 0, 1, 32'h202);
    run_trace(0);
    chk("misalign_cause", 32'(trap_cause), 32'd4);
    chk("misalign_pc", pc, 32'h200);
    do_reset();

    add_instr(32'h1234_5678, 0, 0, 0, 0, 0, 1000, 0, 0, 32'd0);
    chk("fetch_to_cycles", q.size(), 32'd20);
    run_trace(0);
    chk("fetch_to_cause", 32'(trap_cause), 32'd2);
    chk("fetch_to_imem_req", 32'(imem_req), 32'd0);
    do_reset();

    add_instr(32'h0000_0013, 0, 0, 0, 0, 0, 15, 0, 0, 32'd0);
    run_trace(0);
    chk("fetch_ack16_trap", 32'(trap), 32'd0);
    chk("fetch_ack16_pc", pc, 32'h104);

    add_instr(32'h0000_2083, 0, 0, 1, 0, 1, 0, 1000, 0, 32'd0);
    run_trace(0);
    chk("mem_to_cause", 32'(trap_cause), 32'd3);
    do_reset();

    add_instr(32'hFFFF_FFFF, 1, 1, 1, 1, 1, 0, 0, 0, 32'd0);
    run_trace(0);
    chk("illegal_cause", 32'(trap_cause), 32'd1);
    do_reset();

    // reset lands while the ALU is on digit 5
    add_instr(32'h0010_0093, 0, 1, 0, 0, 1, 0, 0, 0, 32'd0);
    while (q.size() > 8) void'(q.pop_back());
    run_trace(1);
    chk("mid_exec_digit", 32'(alu_digit), 32'd5);
    do_reset();
    add_instr(32'h0010_0093, 0, 1, 0, 0, 1, 0, 0, 0, 32'd0);
    run_trace(0);
    chk("restart_pc", pc, 32'h104);

    // reset while a data request is still waiting for its ack
    add_instr(32'h0000_2083, 0, 1, 1, 0, 1, 0, 6, 0, 32'd0);
    while (q.size() > 13) void'(q.pop_back());
    run_trace(1);
    do_reset();

    add_instr(32'h0000_006F, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    run_trace(0);
    add_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    run_trace(0);
    chk("wrap_pc", pc, 32'h0);

    repeat (40) begin
      r_ill = ($urandom_range(0, 15) == 0);
      r_alu = 1'($urandom); r_mem = 1'($urandom); r_we = 1'($urandom); r_wb = 1'($urandom);
      r_bt  = ($urandom_range(0, 3) == 0);
      r_tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
      add_instr($urandom, r_ill, r_alu, r_mem, r_we, r_wb,
                $urandom_range(0, 3), $urandom_range(0, 3), r_bt, r_tgt);
      run_trace(0);
      if (m_trap) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_fsm.md
# ctrl_seq_fsm

Parametrised instruction-sequencing FSM for the serial-ALU RISC-V core. It replaces the fixed three-state control loop with a full fetch / decode / execute / memory / writeback / PC-update sequence. It drives a digit-serial ALU slice directly through an internal digit counter and handshakes with instruction and data memories. Bus errors and illegal instructions are trapped with a cause code instead of hanging.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- DIGIT_W, 4, ALU digit width; XLEN % DIGIT_W == 0 is required (elaboration error otherwise)
- PC_STEP, 4, sequential PC increment; must be a power of two
- RESET_PC, 0, PC value after reset
- MEM_TIMEOUT, 16, maximum number of request cycles without ack; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  equals pc
- imem_ack  in  1  fetch complete, imem_rdata valid
- imem_rdata  in  32  instruction word
- instr_q  out  32  latched instruction, feeds the decoder
- dec_illegal / dec_need_alu / dec_need_mem / dec_mem_we / dec_need_wb  in  1 each  decoder flags, sampled in DECODE
- alu_en  out  1  ALU digit step enable
- alu_digit  out  $clog2(XLEN/DIGIT_W)  current digit index
- alu_first  out  1  first digit, ALU clears carry
- alu_last  out  1  final digit
- dmem_req  out  1  data access request
- dmem_we  out  1  write strobe, valid with dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write pulse
- br_taken  in  1  branch/jump taken, sampled in INCR_PC
- br_target  in  XLEN  branch target, sampled in INCR_PC
- pc  out  XLEN  program counter
- state  out  ctrl_state_t  current state
- trap  out  1  sticky trap flag
- trap_cause  out  3  0 none, 1 illegal, 2 fetch timeout, 3 mem timeout, 4 misaligned target

## Operation
- Reset values: state = FETCH, pc = RESET_PC, instr_q = 0, digit counter = 0, trap = 0, trap_cause = 0, latched flags = 0.
- All request and strobe outputs are decoded combinationally from state.
- FETCH: imem_req = 1. On imem_ack, latch imem_rdata into instr_q and go to DECODE.
- DECODE, one cycle. Latch the dec_* flags. Next state, by priority:
  - dec_illegal -> TRAP(1)
  - dec_need_alu -> EXEC
  - dec_need_mem -> MEM
  - dec_need_wb -> WB
  - otherwise -> INCR_PC
- EXEC runs for NDIG = XLEN/DIGIT_W cycles:
  - alu_en = 1; alu_digit counts 0..NDIG-1
  - alu_first at digit 0; alu_last at digit NDIG-1
  - after the last digit: MEM if need_mem, else WB if need_wb, else INCR_PC
  - the counter resets to 0 on exit
- MEM: dmem_req = 1, dmem_we = the latched dec_mem_we. On dmem_ack: WB if need_wb, else INCR_PC.
- WB: rf_we = 1 for exactly one cycle, then INCR_PC.
- INCR_PC:
  - if br_taken and br_target % PC_STEP != 0 -> TRAP(4); pc is unchanged
  - otherwise pc <= br_taken ? br_target : pc + PC_STEP, wrapping modulo 2^XLEN
  - then FETCH
- Timeout:
  - a counter clears on entry to FETCH or MEM and increments each cycle the request is high without ack
  - if no ack by the MEM_TIMEOUT-th request cycle -> TRAP(2) from FETCH or TRAP(3) from MEM
  - ack in the same cycle as expiry wins; no trap is taken
- TRAP: all requests and strobes are 0, trap = 1, and trap_cause holds. Only rst_n exits TRAP.
- imem_ack / dmem_ack outside FETCH / MEM are ignored.

## Timing
- Fetch with ack in the first request cycle: DECODE follows on the next edge.
- ALU + writeback instruction with zero-wait memory: 4 + NDIG cycles (12 at the defaults).
- Memory-only load (no ALU) with zero wait: FETCH, DECODE, MEM, WB, INCR_PC = 5 cycles.
- pc updates on the clock edge leaving INCR_PC; imem_addr shows the new value in the following FETCH.
- Reset asserted mid-EXEC or mid-MEM: all outputs return to their reset values immediately (asynchronous). Any pending request is dropped without waiting for its ack.

## Structure
- Shared package core_pkg holds:
  - ctrl_state_t, enum logic[2:0]: FETCH, DECODE, EXEC, MEM, WB, INCR_PC, TRAP
  - trap_cause_t with the codes above
- The timeout counter is a natural sub-module, req_timeout: inputs clr, req, ack; output expired. It is instantiated once and shared between FETCH and MEM.
- The digit counter and state register stay in ctrl_seq_fsm.

## Test plan
- Reset with pc = RESET_PC = 0x100, then addi (need_alu, need_wb), ack immediate:
  - alu_digit steps 0..7, alu_first at 0, alu_last at 7
  - rf_we pulses once
  - pc = 0x104 after 12 cycles
- Load (need_alu, need_mem, need_wb) with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles, dmem_we = 0, then rf_we, pc += 4.
- br_taken = 1, br_target = 0x200 -> pc = 0x200. br_target = 0x202 -> TRAP, trap_cause = 4, pc unchanged.
- Timeouts with MEM_TIMEOUT = 16:
  - imem_ack never asserted -> TRAP on cycle 16 with cause 2, imem_req then 0
  - ack exactly on cycle 16 -> no trap
- dec_illegal = 1 -> TRAP with cause 1. Subsequent acks are ignored; rst_n pulse returns to FETCH at RESET_PC.
- rst_n low during EXEC digit 5 -> alu_en = 0 and alu_digit = 0 immediately; clean restart afterwards.
- Wrap-around: pc = 0xFFFFFFFC, sequential step -> pc = 0.
